// File: rtl/div_restore.sv
// Signed restoring divider: 2*BIT_LEN-bit dividend by BIT_LEN-bit divisor, truncating,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow detection.
module div_restore #(
  parameter int BIT_LEN = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [2*BIT_LEN-1:0]   in1,
  input  logic [BIT_LEN-1:0]     in2,
  output logic [BIT_LEN-1:0]     quo,
  output logic [BIT_LEN-1:0]     rem,
  output logic                   err,
  output logic                   out_r,
  output logic [1:0]             dbg_state
);

  localparam int W  = BIT_LEN;
  localparam int CW = $clog2(W) + 1;
  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [W:0]      pr_q;     // partial remainder, one guard bit for the shifted trial
  logic [W-1:0]    lo_q;     // low dividend bits still to be shifted in
  logic [W-1:0]    q_q;      // quotient magnitude
  logic [W:0]      d_q;      // divisor magnitude, extra bit holds |-2^(W-1)|
  logic            s1_q, s2_q, ovf_q;
  logic [W-1:0]    quo_q, rem_q;
  logic            err_q, out_r_q;

  logic [2*W:0]    ext1, mag1;
  logic [W:0]      ext2, mag2;
  logic            hi_ovf;
  logic [W:0]      trial, pr_d;
  logic            ge;
  logic [W-1:0]    q_d;
  logic            neg, q_ovf;
  logic [W-1:0]    quo_fix, rem_fix;

  always_comb begin
    ext1   = {in1[2*W-1], in1};
    mag1   = ext1[2*W] ? (~ext1 + 1'b1) : ext1;
    ext2   = {in2[W-1], in2};
    mag2   = ext2[W] ? (~ext2 + 1'b1) : ext2;
    // A zero divisor also lands here, since any high half is >= 0.
    hi_ovf = ({1'b0, mag1[2*W-1:W]} >= mag2);

    trial  = {pr_q[W-1:0], lo_q[W-1]};
    ge     = (trial >= d_q);
    pr_d   = ge ? (trial - d_q) : trial;
    q_d    = {q_q[W-2:0], ge};

    neg     = s1_q ^ s2_q;
    q_ovf   = ovf_q | (neg ? (q_q > HALF) : (q_q >= HALF));
    quo_fix = neg ? (~q_q + 1'b1) : q_q;
    rem_fix = s1_q ? (~pr_q[W-1:0] + 1'b1) : pr_q[W-1:0];
  end

  // start is a level request taken only in IDLE; out_r stays high from FIX until the
  // next capture, and DONE waits for start low so a held request cannot retrigger.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      lo_q    <= '0;
      q_q     <= '0;
      d_q     <= '0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      out_r_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            pr_q    <= {1'b0, mag1[2*W-1:W]};
            lo_q    <= mag1[W-1:0];
            d_q     <= mag2;
            s1_q    <= in1[2*W-1];
            s2_q    <= in2[W-1];
            ovf_q   <= hi_ovf;
            q_q     <= '0;
            cnt_q   <= '0;
            out_r_q <= 1'b0;
            state_q <= CALC;
          end
        end
        CALC: begin
          pr_q  <= pr_d;
          lo_q  <= {lo_q[W-2:0], 1'b0};
          q_q   <= q_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CW'(W - 1)) state_q <= FIX;
        end
        FIX: begin
          if (q_ovf) begin
            quo_q <= '0;
            rem_q <= '0;
            err_q <= 1'b1;
          end else begin
            quo_q <= quo_fix;
            rem_q <= rem_fix;
            err_q <= 1'b0;
          end
          out_r_q <= 1'b1;
          state_q <= DONE;
        end
        DONE: begin
          if (!start) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign quo       = quo_q;
  assign rem       = rem_q;
  assign err       = err_q;
  assign out_r     = out_r_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_div_restore.sv
// Bench for div_restore (BIT_LEN=4): directed vectors feed an expected queue, and a
// monitor pops and compares value and latency on every out_r rise.
module tb_div_restore;

  localparam int W = 4;

  logic           clk;
  logic           rstn;
  logic           start;
  logic [2*W-1:0] in1;
  logic [W-1:0]   in2;
  logic [W-1:0]   quo, rem;
  logic           err, out_r;
  logic [1:0]     dbg_state;

  div_restore #(.BIT_LEN(W)) dut (
    .clk(clk), .rstn(rstn), .start(start), .in1(in1), .in2(in2),
    .quo(quo), .rem(rem), .err(err), .out_r(out_r), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 16'd1;

  // scoreboard: {capture cycle[15:0], err, quo[3:0], rem[3:0]}
  logic [24:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int rise_cnt = 0;
  logic out_r_prev = 1'b0;

  always @(negedge clk) begin
    logic [24:0] item;
    logic [15:0] lat;
    if (out_r && !out_r_prev) begin
      rise_cnt++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result got err=%0b quo=%h rem=%h, no result pending", err, quo, rem);
      end else begin
        item = exp_q.pop_front();
        lat  = cyc - item[24:9];
        if ({err, quo, rem} !== item[8:0] || lat != 16'd5) begin
          errors++;
          $display("FAIL result got err=%0b quo=%h rem=%h lat=%0d, want err=%0b quo=%h rem=%h lat=5",
                   err, quo, rem, lat, item[8], item[7:4], item[3:0]);
        end
      end
    end
    out_r_prev = out_r;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  // driver tasks
  task automatic issue(input logic [7:0] a, input logic [3:0] b,
                       input logic [3:0] eq, input logic [3:0] er, input logic ee);
    @(negedge clk);
    in1 = a; in2 = b; start = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({cyc, ee, eq, er});
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && !out_r; i++) @(negedge clk);
    if (!out_r) begin
      checks++;
      errors++;
      $display("FAIL timeout got out_r=0 want out_r=1 within 20 cycles");
    end
  endtask

  task automatic run_op(input logic [7:0] a, input logic [3:0] b,
                        input logic [3:0] eq, input logic [3:0] er, input logic ee);
    issue(a, b, eq, er, ee);
    @(negedge clk);
    start = 1'b0;
    in1 = 8'($urandom_range(0, 255));
    in2 = 4'($urandom_range(0, 15));
    wait_done();
    @(negedge clk);
    @(negedge clk);
    check("hold_idle", {23'd0, out_r, err, quo, rem}, {23'd0, 1'b1, ee, eq, er});
  endtask

  logic [7:0] v_a  [14] = '{8'h15, 8'hEB, 8'h15, 8'hF8, 8'h08, 8'h10, 8'h40,
                            8'h80, 8'h32, 8'hCE, 8'h3F, 8'h00, 8'hC1, 8'h7F};
  logic [3:0] v_b  [14] = '{4'h4, 4'h4, 4'hC, 4'h1, 4'h1, 4'h0, 4'h2,
                            4'h8, 4'h7, 4'h7, 4'h8, 4'h3, 4'h8, 4'h8};
  logic [3:0] v_q  [14] = '{4'h5, 4'hB, 4'hB, 4'h8, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h7, 4'h9, 4'h9, 4'h0, 4'h7, 4'h0};
  logic [3:0] v_r  [14] = '{4'h1, 4'hF, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0,
                            4'h0, 4'h1, 4'hF, 4'h7, 4'h0, 4'h9, 4'h0};
  logic       v_e  [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                            1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  initial begin
    int r0;
    rstn = 1'b0; start = 1'b1; in1 = 8'h15; in2 = 4'h4;
    #12;
    check("reset_outputs", {21'd0, dbg_state, out_r, err, quo, rem}, 32'd0);
    // release with start high: capture on the first edge after release
    #11 rstn = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({cyc, 1'b0, 4'h5, 4'h1});
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    for (int i = 0; i < 14; i++) run_op(v_a[i], v_b[i], v_q[i], v_r[i], v_e[i]);

    // held start: one result only, then a fresh request after start drops
    r0 = rise_cnt;
    issue(8'h15, 4'h4, 4'h5, 4'h1, 1'b0);
    repeat (20) @(negedge clk);
    check("held_start_single_rise", rise_cnt - r0, 32'd1);
    start = 1'b0;
    issue(8'hEB, 4'hC, 4'h5, 4'hF, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("out_r_low_in_calc", {31'd0, out_r}, 32'd0);
    end
    wait_done();
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);

    // half-cycle reset pulse mid-computation
    issue(8'h32, 4'h7, 4'h7, 4'h1, 1'b0);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rstn = 1'b0;
    #1;
    check("reset_mid_calc", {21'd0, dbg_state, out_r, err, quo, rem}, 32'd0);
    exp_q.delete();
    #4 rstn = 1'b1;
    r0 = rise_cnt;
    repeat (10) @(negedge clk);
    check("no_result_after_reset", {31'd0, out_r}, 32'd0);
    check("no_rise_after_reset", rise_cnt - r0, 32'd0);
    run_op(8'hCE, 4'h7, 4'h9, 4'hF, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000ns");
    $fatal(1);
  end

endmodule

// File: doc/div_restore.md
DIV_RESTORE -- requirements
Module: div_restore

Interface
REQ-001 Parameter BIT_LEN, default 4, sets the divisor, quotient and remainder width; the dividend width is 2*BIT_LEN.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rstn  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  level request, active-high; sampled only in IDLE.
REQ-005 in1  input  2*BIT_LEN  dividend, two's complement signed.
REQ-006 in2  input  BIT_LEN  divisor, two's complement signed.
REQ-007 quo  output  BIT_LEN  quotient, signed, registered.
REQ-008 rem  output  BIT_LEN  remainder, signed, registered.
REQ-009 err  output  1  divide-by-zero or quotient overflow flag, registered.
REQ-010 out_r  output  1  result-ready flag, registered.

Function
REQ-011 The FSM SHALL have four states: IDLE, CALC, FIX and DONE.
REQ-012 On the edge where state is IDLE and start=1, the block SHALL latch in1/in2, sign bits and magnitudes, clear the iteration counter, clear out_r, and enter CALC.
REQ-013 In IDLE with start=0, the block SHALL hold all outputs and registers.
REQ-014 CALC SHALL perform one restoring-division step per cycle on the unsigned magnitudes: shift partial remainder left, trial-subtract |in2|, keep the difference when non-negative, and shift the quotient bit in; this SHALL take exactly BIT_LEN cycles, then enter FIX.
REQ-015 Operands SHALL be ignored after capture; changes on in1/in2/start during CALC/FIX SHALL have no effect.
REQ-016 FIX SHALL apply signs in one cycle: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign (truncating division); then it SHALL register quo/rem/err, set out_r=1, and enter DONE.
REQ-017 Latency: out_r SHALL rise on the (BIT_LEN+1)th rising edge after the capture edge, independent of operand values, including error cases.
REQ-018 err SHALL be 1 when in2=0, and quo and rem SHALL both be 0 in that case.
REQ-019 err SHALL be 1 when the high BIT_LEN bits of |in1| are >= |in2| (magnitude quotient exceeds BIT_LEN bits), and quo and rem SHALL both be 0 in that case.
REQ-020 err SHALL be 1 when the signed quotient is outside [-2^(BIT_LEN-1), 2^(BIT_LEN-1)-1]; for example, magnitude 2^(BIT_LEN-1) SHALL be legal only for a negative result; quo and rem SHALL both be 0 in that case.
REQ-021 DONE SHALL hold the outputs with out_r=1, and SHALL go to IDLE on the first edge with start=0.
REQ-022 A start held high continuously SHALL NOT retrigger: a new operation requires start to be seen low in DONE first.
REQ-023 quo, rem, err and out_r SHALL remain valid and stable in IDLE until the next capture edge clears out_r.
REQ-024 The magnitude of the most negative dividend/divisor (e.g. 8'h80, 4'h8) SHALL be computed without loss using one extra internal bit.

Reset
REQ-025 While rstn=0, asynchronously and regardless of state: state=IDLE, quo=0, rem=0, err=0, out_r=0, and all internal registers are 0.
REQ-026 Reset asserted mid-CALC or mid-FIX SHALL abort the operation with no partial result visible; after release the block SHALL wait in IDLE for start.
REQ-027 If start=1 at reset release, the block SHALL capture on the first rising edge after rstn goes high.

Verification (BIT_LEN=4)
REQ-028 in1=8'h15 (21), in2=4'h4 -> quo=4'h5, rem=4'h1, err=0, out_r rising exactly 5 edges after the capture edge.
REQ-029 in1=8'hEB (-21), in2=4'h4 -> quo=4'hB (-5), rem=4'hF (-1); in1=8'h15, in2=4'hC (-4) -> quo=4'hB, rem=4'h1; both with err=0.
REQ-030 in1=8'hF8 (-8), in2=4'h1 -> quo=4'h8, rem=0, err=0; in1=8'h08, in2=4'h1 -> err=1, quo=0, rem=0.
REQ-031 in1=8'h10, in2=4'h0 -> err=1, quo=0, rem=0 at the same 5-edge latency; in1=8'h40, in2=4'h2 -> err=1.
REQ-032 start held high for 20 cycles -> exactly one out_r rise; then drop start for 1 cycle and reassert it with new operands -> the second result follows, and out_r is low during its computation.
REQ-033 rstn pulsed low for half a cycle during CALC -> all outputs 0 immediately; no out_r until a fresh start; the next operation returns a correct result.
